issue_brt_mc: RTL and testbench
===============================

# issue_brt_mc

Multi-channel, parametrised branch-record table for the issue stage. It captures the predictor's per-branch outcome (taken-and-hit, target) keyed by branch ID. It checks up to `NCH` branch resolutions per cycle against the stored prediction. It reports the single oldest misprediction as a registered override carrying the corrected direction and target, and invalidates all younger records.

## Interface
Parameters:
- `BID_W`, default 4: branch-ID width; MSB is the wrap bit; index = `bid[BID_W-2:0]`.
- `DEPTH`, default `2**(BID_W-1)`: number of entries; must equal `2**(BID_W-1)`.
- `NCH`, default 2: number of resolution channels.
- `ADDR_W`, default 32: target width.

Ports:
- `clk`, in, 1: clock.
- `resetn`, in, 1: reset, synchronous, active-low.
- `i_bp_valid`, in, 1: prediction record write.
- `i_bp_bid`, in, `BID_W`: ID of the predicted branch.
- `i_bp_taken`, in, 1: predicted taken.
- `i_bp_hit`, in, 1: BTB hit.
- `i_bp_target`, in, `ADDR_W`: predicted target.
- `i_bc_valid`, in, `NCH`: per-channel resolution valid.
- `i_bc_bid`, in, `NCH*BID_W`: resolved IDs, channel c at `[c*BID_W +: BID_W]`.
- `i_bc_taken`, in, `NCH`: actual direction.
- `i_bc_target`, in, `NCH*ADDR_W`: actual target.
- `i_head_bid`, in, `BID_W`: oldest in-flight branch ID (age reference).
- `i_flush`, in, 1: global pipeline flush.
- `o_bc_valid`, out, `NCH`: registered echo of resolutions.
- `o_bc_bid`, out, `NCH*BID_W`: registered echo of IDs.
- `o_bco_valid`, out, 1: override (misprediction) pulse.
- `o_bco_bid`, out, `BID_W`: ID of the mispredicted branch.
- `o_bco_taken`, out, 1: corrected direction.
- `o_bco_target`, out, `ADDR_W`: corrected target.
- `o_stale`, out, 1: sticky flag; set when a resolution hits an invalid entry.

## Operation
- bp inputs are registered (stage IR). In the next cycle the entry at `idx(bp_bid_IR)` is written: `taken <= taken&hit`, `target`, `bid` (full, with wrap bit), `valid <= 1`.
- Per channel c, mismatch rule:
  - `mt = taken_c != entry.taken`
  - `mg = taken_c & (target_c != entry.target)`
  - `ovr_c = valid_c & entry.valid & entry.bid == bid_c & (mt | mg)`
- Bypass: if `bp_valid_IR` and `idx(bp_bid_IR) == idx(bid_c)` in the same cycle, compare against the IR fields, not the array.
- Resolution with no matching valid entry (invalid, or stored bid wrap bit differs): no override; set `o_stale`. It is cleared only by reset.
- Age = `(bid - i_head_bid) mod 2**BID_W`; smaller is older. Among overriding channels, the one with minimum age wins; on a tie, the lower channel index wins.
- Every resolved entry, mismatching or not, gets `valid <= 0` at the edge.
- On a selected override with bid B, every entry whose age is greater than age(B) also gets `valid <= 0` at the same edge.
- If a bp write in the same cycle is younger than B, it is dropped; otherwise it is written.
- `i_flush`: all `valid <= 0` next edge; pending bp_IR write is dropped; `o_bco_valid` for that cycle is suppressed (forced 0). `o_bc_valid` echoes still pass through.
- Two channels resolving the same bid in one cycle is illegal; the block still behaves deterministically (lower channel wins).

## Timing
- bp: `i_bp_*` at cycle T, array updated at edge T+2. It is visible to resolutions at T+1 via the bypass.
- bc: `i_bc_*` at T; `o_bc_*` and `o_bco_*` valid in cycle T+1 (one register stage). Invalidation takes effect at the T→T+1 edge.
- Reset:
  - Outputs: `o_bc_valid=0`, `o_bco_valid=0`, `o_stale=0`.
  - Internal state: all entry valids 0, `bp_valid_IR=0`.
  - Data registers are not reset.
- `o_bco_valid` is a single-cycle pulse per override; there is no back-pressure.

## Structure
- Package `issue_brt_pkg`:
  - `brt_entry_t` struct {valid, bid, taken, target}.
  - `bid_age()` function.
  - Default parameter constants.
- Sub-module `issue_brt_agesel`: NCH-way oldest-select. Inputs: request vector, bids, `i_head_bid`. Outputs: one-hot grant and encoded index. Purely combinational.

## Test plan
- Write bid=3 taken=1 hit=1 target=0x1000; resolve bid=3 taken=1 target=0x1000 → `o_bc_valid[0]=1`, `o_bco_valid=0` at T+1.
- Write bid=5 taken=1 hit=0; resolve bid=5 taken=1 target=0x2000 → `o_bco_valid=1`, bid=5, taken=1, target=0x2000.
- Head=2, entries 2..7 valid; ch0 overrides bid=6 and ch1 overrides bid=4 in the same cycle → override bid=4; entries 4..7 invalid afterwards; a later resolve of bid=6 sets `o_stale`.
- bp write bid=1 and resolve bid=1 one cycle later, with a mismatching direction → bypass detects it; `o_bco_valid=1`.
- Write bid=9 (idx 1, wrap=1) over a stale bid=1; resolve bid=1 → no override, `o_stale=1`.
- Assert `i_flush` together with an overriding resolution → `o_bco_valid=0`; all entries invalid; reset mid-stream → all outputs 0 next cycle.

Source files
------------

// File: rtl/issue_brt_pkg.sv
// Shared types, default sizes and the age helper for the issue-stage branch-record table.
// Age is the distance of a branch ID from the oldest in-flight ID, modulo the ID space.
package issue_brt_pkg;

    localparam int BRT_BID_W  = 4;
    localparam int BRT_NCH    = 2;
    localparam int BRT_ADDR_W = 32;

    typedef struct packed {
        logic                  valid;
        logic [BRT_BID_W-1:0]  bid;
        logic                  taken;
        logic [BRT_ADDR_W-1:0] target;
    } brt_entry_t;

    // Callers zero-extend IDs to 32 bits; width selects the modulus 2**width.
    function automatic logic [31:0] bid_age(input logic [31:0] bid,
                                            input logic [31:0] head,
                                            input int          width);
        logic [31:0] mask;
        mask = (32'd1 << width) - 32'd1;
        return (bid - head) & mask;
    endfunction

endpackage

// File: rtl/issue_brt_agesel.sv
// Combinational oldest-first selector across resolution channels.
// Equal ages resolve to the lowest channel index.
module issue_brt_agesel
    import issue_brt_pkg::*;
#(
    parameter  int BID_W = BRT_BID_W,
    parameter  int NCH   = BRT_NCH,
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0]       req_i,
    input  logic [NCH*BID_W-1:0] bid_i,
    input  logic [BID_W-1:0]     head_bid_i,
    output logic [NCH-1:0]       gnt_o,
    output logic [IDX_W-1:0]     idx_o
);

    logic [31:0] age_s;
    logic [31:0] best_age_s;
    logic        found_s;

    // Strict less-than keeps the earlier channel on an age tie.
    always_comb begin
        gnt_o      = '0;
        idx_o      = '0;
        age_s      = 32'd0;
        best_age_s = 32'd0;
        found_s    = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            age_s = bid_age(32'(bid_i[c*BID_W +: BID_W]), 32'(head_bid_i), BID_W);
            if (req_i[c] && (!found_s || (age_s < best_age_s))) begin
                found_s    = 1'b1;
                best_age_s = age_s;
                idx_o      = IDX_W'(c);
            end else begin
                found_s    = found_s;
            end
        end
        if (found_s) begin
            gnt_o[idx_o] = 1'b1;
        end else begin
            gnt_o = '0;
        end
    end

endmodule

// File: rtl/issue_brt_mc.sv
// Branch-record table: stores predictions by branch ID, checks NCH resolutions per cycle
// and emits the oldest misprediction as a registered override, squashing younger records.
module issue_brt_mc
    import issue_brt_pkg::*;
#(
    parameter int BID_W  = BRT_BID_W,
    parameter int DEPTH  = 2 ** (BID_W - 1),
    parameter int NCH    = BRT_NCH,
    parameter int ADDR_W = BRT_ADDR_W
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  i_bp_valid,
    input  logic [BID_W-1:0]      i_bp_bid,
    input  logic                  i_bp_taken,
    input  logic                  i_bp_hit,
    input  logic [ADDR_W-1:0]     i_bp_target,
    input  logic [NCH-1:0]        i_bc_valid,
    input  logic [NCH*BID_W-1:0]  i_bc_bid,
    input  logic [NCH-1:0]        i_bc_taken,
    input  logic [NCH*ADDR_W-1:0] i_bc_target,
    input  logic [BID_W-1:0]      i_head_bid,
    input  logic                  i_flush,
    output logic [NCH-1:0]        o_bc_valid,
    output logic [NCH*BID_W-1:0]  o_bc_bid,
    output logic                  o_bco_valid,
    output logic [BID_W-1:0]      o_bco_bid,
    output logic                  o_bco_taken,
    output logic [ADDR_W-1:0]     o_bco_target,
    output logic                  o_stale
);

    localparam int IW = BID_W - 1;
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic              bp_valid_q;
    logic [BID_W-1:0]  bp_bid_q;
    logic              bp_taken_q;
    logic [ADDR_W-1:0] bp_target_q;

    logic [DEPTH-1:0]  ent_valid_q;
    logic [DEPTH-1:0]  ent_valid_d;
    logic [BID_W-1:0]  ent_bid_q    [DEPTH];
    logic              ent_taken_q  [DEPTH];
    logic [ADDR_W-1:0] ent_target_q [DEPTH];

    logic [BID_W-1:0]  bc_bid_s    [NCH];
    logic [ADDR_W-1:0] bc_target_s [NCH];
    logic [NCH-1:0]    match_s, ovr_s, stale_s, gnt_s;
    logic [CW-1:0]     sel_s;
    logic [IW-1:0]     lk_idx_s;
    logic              lk_valid_s, lk_taken_s;
    logic [BID_W-1:0]  lk_bid_s, row_bid_s;
    logic [ADDR_W-1:0] lk_target_s;
    logic              any_ovr_s, wr_en_s;
    logic [31:0]       sel_age_s;

    for (genvar c = 0; c < NCH; c++) begin : g_unpack
        assign bc_bid_s[c]    = i_bc_bid[c*BID_W +: BID_W];
        assign bc_target_s[c] = i_bc_target[c*ADDR_W +: ADDR_W];
    end

    // Per-channel lookup; a record still in the input register bypasses the array.
    always_comb begin
        match_s     = '0;
        ovr_s       = '0;
        stale_s     = '0;
        lk_idx_s    = '0;
        lk_valid_s  = 1'b0;
        lk_bid_s    = '0;
        lk_taken_s  = 1'b0;
        lk_target_s = '0;
        for (int c = 0; c < NCH; c++) begin
            lk_idx_s = bc_bid_s[c][IW-1:0];
            if (bp_valid_q && (bp_bid_q[IW-1:0] == lk_idx_s)) begin
                lk_valid_s  = 1'b1;
                lk_bid_s    = bp_bid_q;
                lk_taken_s  = bp_taken_q;
                lk_target_s = bp_target_q;
            end else begin
                lk_valid_s  = ent_valid_q[lk_idx_s];
                lk_bid_s    = ent_bid_q[lk_idx_s];
                lk_taken_s  = ent_taken_q[lk_idx_s];
                lk_target_s = ent_target_q[lk_idx_s];
            end
            match_s[c] = i_bc_valid[c] && lk_valid_s && (lk_bid_s == bc_bid_s[c]);
            ovr_s[c]   = match_s[c] && ((i_bc_taken[c] != lk_taken_s) ||
                         (i_bc_taken[c] && (bc_target_s[c] != lk_target_s)));
            stale_s[c] = i_bc_valid[c] && !match_s[c];
        end
    end

    issue_brt_agesel #(
        .BID_W (BID_W),
        .NCH   (NCH)
    ) u_agesel (
        .req_i      (ovr_s),
        .bid_i      (i_bc_bid),
        .head_bid_i (i_head_bid),
        .gnt_o      (gnt_s),
        .idx_o      (sel_s)
    );

    assign any_ovr_s = |gnt_s;
    assign sel_age_s = bid_age(32'(bc_bid_s[sel_s]), 32'(i_head_bid), BID_W);
    assign wr_en_s   = bp_valid_q && !i_flush &&
                       !(any_ovr_s && (bid_age(32'(bp_bid_q), 32'(i_head_bid), BID_W) > sel_age_s));

    // Valid update order: write, consume resolved records, squash younger, then flush.
    always_comb begin
        ent_valid_d = ent_valid_q;
        row_bid_s   = '0;
        if (wr_en_s) begin
            ent_valid_d[bp_bid_q[IW-1:0]] = 1'b1;
        end else begin
            ent_valid_d = ent_valid_d;
        end
        for (int c = 0; c < NCH; c++) begin
            if (match_s[c]) begin
                ent_valid_d[bc_bid_s[c][IW-1:0]] = 1'b0;
            end else begin
                ent_valid_d = ent_valid_d;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            row_bid_s = (wr_en_s && (bp_bid_q[IW-1:0] == IW'(i))) ? bp_bid_q : ent_bid_q[i];
            if (any_ovr_s && (bid_age(32'(row_bid_s), 32'(i_head_bid), BID_W) > sel_age_s)) begin
                ent_valid_d[i] = 1'b0;
            end else begin
                ent_valid_d[i] = ent_valid_d[i];
            end
        end
        if (i_flush) begin
            ent_valid_d = '0;
        end else begin
            ent_valid_d = ent_valid_d;
        end
    end

    // Control state and output flags.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            bp_valid_q  <= 1'b0;
            ent_valid_q <= '0;
            o_bc_valid  <= '0;
            o_bco_valid <= 1'b0;
            o_stale     <= 1'b0;
        end else begin
            bp_valid_q  <= i_bp_valid;
            ent_valid_q <= ent_valid_d;
            o_bc_valid  <= i_bc_valid;
            o_bco_valid <= any_ovr_s && !i_flush;
            o_stale     <= o_stale | (|stale_s);
        end
    end

    // Data path registers are deliberately left without reset.
    always_ff @(posedge clk) begin
        bp_bid_q    <= i_bp_bid;
        bp_taken_q  <= i_bp_taken & i_bp_hit;
        bp_target_q <= i_bp_target;
        if (wr_en_s) begin
            ent_bid_q[bp_bid_q[IW-1:0]]    <= bp_bid_q;
            ent_taken_q[bp_bid_q[IW-1:0]]  <= bp_taken_q;
            ent_target_q[bp_bid_q[IW-1:0]] <= bp_target_q;
        end
        o_bc_bid     <= i_bc_bid;
        o_bco_bid    <= bc_bid_s[sel_s];
        o_bco_taken  <= i_bc_taken[sel_s];
        o_bco_target <= bc_target_s[sel_s];
    end

endmodule

// File: tb/tb_issue_brt_mc.sv
// Bench for issue_brt_mc: directed vector table for the listed scenarios, then random
// traffic checked every cycle against an abstract table model.
module tb_issue_brt_mc;
    import issue_brt_pkg::*;

    localparam int BID_W  = 4;
    localparam int NCH    = 2;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 8;

    logic                  clk = 1'b0;
    logic                  resetn;
    logic                  i_bp_valid, i_bp_taken, i_bp_hit, i_flush;
    logic [BID_W-1:0]      i_bp_bid, i_head_bid;
    logic [ADDR_W-1:0]     i_bp_target;
    logic [NCH-1:0]        i_bc_valid, i_bc_taken;
    logic [NCH*BID_W-1:0]  i_bc_bid;
    logic [NCH*ADDR_W-1:0] i_bc_target;
    logic [NCH-1:0]        o_bc_valid;
    logic [NCH*BID_W-1:0]  o_bc_bid;
    logic                  o_bco_valid, o_bco_taken, o_stale;
    logic [BID_W-1:0]      o_bco_bid;
    logic [ADDR_W-1:0]     o_bco_target;

    always #5 clk = ~clk;

    issue_brt_mc #(.BID_W(BID_W), .DEPTH(DEPTH), .NCH(NCH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .resetn(resetn),
        .i_bp_valid(i_bp_valid), .i_bp_bid(i_bp_bid), .i_bp_taken(i_bp_taken),
        .i_bp_hit(i_bp_hit), .i_bp_target(i_bp_target),
        .i_bc_valid(i_bc_valid), .i_bc_bid(i_bc_bid), .i_bc_taken(i_bc_taken),
        .i_bc_target(i_bc_target), .i_head_bid(i_head_bid), .i_flush(i_flush),
        .o_bc_valid(o_bc_valid), .o_bc_bid(o_bc_bid), .o_bco_valid(o_bco_valid),
        .o_bco_bid(o_bco_bid), .o_bco_taken(o_bco_taken), .o_bco_target(o_bco_target),
        .o_stale(o_stale)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    brt_entry_t           mdl [DEPTH];
    brt_entry_t           pend;
    logic [NCH-1:0]       exp_bc_valid;
    logic [NCH*BID_W-1:0] exp_bc_bid;
    logic                 exp_bco_valid, exp_bco_taken;
    logic [BID_W-1:0]     exp_bco_bid;
    logic [ADDR_W-1:0]    exp_bco_target;
    logic                 exp_stale = 1'b0;

    function automatic int age(int b, int h);
        return (b - h + (1 << BID_W)) % (1 << BID_W);
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        brt_entry_t       e;
        int               win, win_age, a, ix;
        logic [BID_W-1:0] b;
        bit               hit [NCH];
        exp_bc_bid   = i_bc_bid;
        exp_bc_valid = resetn ? i_bc_valid : '0;
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) mdl[i].valid = 1'b0;
            pend.valid    = 1'b0;
            exp_bco_valid = 1'b0;
            exp_stale     = 1'b0;
            return;
        end
        win = -1;
        win_age = 0;
        for (int c = 0; c < NCH; c++) begin
            hit[c] = 1'b0;
            if (!i_bc_valid[c]) continue;
            b  = i_bc_bid[c*BID_W +: BID_W];
            ix = int'(b) % DEPTH;
            e  = (pend.valid && (int'(pend.bid) % DEPTH == ix)) ? pend : mdl[ix];
            if (e.valid && e.bid == b) begin
                hit[c] = 1'b1;
                if ((i_bc_taken[c] != e.taken) ||
                    (i_bc_taken[c] && i_bc_target[c*ADDR_W +: ADDR_W] != e.target)) begin
                    a = age(int'(b), int'(i_head_bid));
                    if (win < 0 || a < win_age) begin
                        win = c;
                        win_age = a;
                    end
                end
            end else begin
                exp_stale = 1'b1;
            end
        end
        exp_bco_valid = (win >= 0) && !i_flush;
        if (win >= 0) begin
            exp_bco_bid    = i_bc_bid[win*BID_W +: BID_W];
            exp_bco_taken  = i_bc_taken[win];
            exp_bco_target = i_bc_target[win*ADDR_W +: ADDR_W];
        end
        if (pend.valid && !i_flush &&
            !(win >= 0 && age(int'(pend.bid), int'(i_head_bid)) > win_age))
            mdl[int'(pend.bid) % DEPTH] = pend;
        for (int c = 0; c < NCH; c++)
            if (hit[c]) mdl[int'(i_bc_bid[c*BID_W +: BID_W]) % DEPTH].valid = 1'b0;
        if (win >= 0)
            for (int i = 0; i < DEPTH; i++)
                if (age(int'(mdl[i].bid), int'(i_head_bid)) > win_age) mdl[i].valid = 1'b0;
        if (i_flush)
            for (int i = 0; i < DEPTH; i++) mdl[i].valid = 1'b0;
        pend = {i_bp_valid, i_bp_bid, i_bp_taken & i_bp_hit, i_bp_target};
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("bc_valid", 64'(o_bc_valid), 64'(exp_bc_valid));
        check("bc_bid", 64'(o_bc_bid), 64'(exp_bc_bid));
        check("bco_valid", 64'(o_bco_valid), 64'(exp_bco_valid));
        if (exp_bco_valid) begin
            check("bco_bid", 64'(o_bco_bid), 64'(exp_bco_bid));
            check("bco_taken", 64'(o_bco_taken), 64'(exp_bco_taken));
            check("bco_target", 64'(o_bco_target), 64'(exp_bco_target));
        end
        check("stale", 64'(o_stale), 64'(exp_stale));
    endtask

    typedef struct {
        logic        rst;
        logic        bpv;
        logic [3:0]  bpb;
        logic        bpt, bph;
        logic [31:0] bptg;
        logic [1:0]  bcv;
        logic [3:0]  b0, b1;
        logic [1:0]  bct;
        logic [31:0] tg0, tg1;
        logic [3:0]  head;
        logic        flush;
        logic        xbco;
        logic [3:0]  xbid;
        logic        xt;
        logic [31:0] xtg;
        logic        xst;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic bpv, logic [3:0] bpb, logic bpt, logic bph,
                                logic [31:0] bptg, logic [1:0] bcv, logic [3:0] b0, logic [3:0] b1,
                                logic [1:0] bct, logic [31:0] tg0, logic [31:0] tg1, logic [3:0] head,
                                logic flush, logic xbco, logic [3:0] xbid, logic xt,
                                logic [31:0] xtg, logic xst);
        vec_t v;
        v = '{rst, bpv, bpb, bpt, bph, bptg, bcv, b0, b1, bct, tg0, tg1, head, flush,
              xbco, xbid, xt, xtg, xst};
        return v;
    endfunction

    task automatic idle_inputs();
        i_bp_valid = 1'b0; i_bp_bid = '0; i_bp_taken = 1'b0; i_bp_hit = 1'b0; i_bp_target = '0;
        i_bc_valid = '0; i_bc_bid = '0; i_bc_taken = '0; i_bc_target = '0;
        i_head_bid = '0; i_flush = 1'b0;
    endtask

    initial begin
        logic [BID_W-1:0] rb;
        int               ix;
        resetn = 1'b0;
        idle_inputs();
        pend = '0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        cycle();
        cycle();

        // rst bpv bpb t h bptg | bcv b0 b1 bct tg0 tg1 head flush | xbco xbid xt xtg xst
        tbl.push_back(mk(0, 1, 3, 1, 1, 32'h1000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 3, 0, 1, 32'h1000, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 5, 1, 0, 32'hdead, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 5, 0, 1, 32'h2000, 0, 0, 0, 1, 5, 1, 32'h2000, 0));
        for (int k = 2; k < 8; k++)
            tbl.push_back(mk(0, 1, 4'(k), 1, 1, 32'(k * 256), 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3, 6, 4, 0, 32'h66, 32'h44, 2, 0, 1, 4, 0, 32'h44, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 6, 0, 1, 32'h600, 0, 2, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 1, 32'h1110, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 32'h1114, 0, 0, 0, 1, 1, 0, 32'h1114, 0));
        tbl.push_back(mk(0, 1, 1, 1, 1, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 9, 1, 1, 32'h90, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 32'h10, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2, 1, 1, 32'h20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 32'h20, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 2, 0, 1, 32'h20, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 3, 1, 1, 32'h30, 3, 2, 3, 3, 32'h1, 32'h2, 0, 0, 0, 0, 0, 0, 0));

        foreach (tbl[r]) begin
            resetn      = !tbl[r].rst;
            i_bp_valid  = tbl[r].bpv;
            i_bp_bid    = tbl[r].bpb;
            i_bp_taken  = tbl[r].bpt;
            i_bp_hit    = tbl[r].bph;
            i_bp_target = tbl[r].bptg;
            i_bc_valid  = tbl[r].bcv;
            i_bc_bid    = {tbl[r].b1, tbl[r].b0};
            i_bc_taken  = tbl[r].bct;
            i_bc_target = {tbl[r].tg1, tbl[r].tg0};
            i_head_bid  = tbl[r].head;
            i_flush     = tbl[r].flush;
            cycle();
            check($sformatf("row%0d_bco_valid", r), 64'(o_bco_valid), 64'(tbl[r].xbco));
            check($sformatf("row%0d_stale", r), 64'(o_stale), 64'(tbl[r].xst));
            if (tbl[r].xbco) begin
                check($sformatf("row%0d_bco_bid", r), 64'(o_bco_bid), 64'(tbl[r].xbid));
                check($sformatf("row%0d_bco_taken", r), 64'(o_bco_taken), 64'(tbl[r].xt));
                check($sformatf("row%0d_bco_target", r), 64'(o_bco_target), 64'(tbl[r].xtg));
            end
        end

        // Random traffic biased towards IDs and targets that are actually in the table.
        for (int n = 0; n < 4000; n++) begin
            resetn      = ($urandom_range(0, 199) != 0);
            i_flush     = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 7) == 0) i_head_bid = BID_W'($urandom);
            i_bp_valid  = 1'($urandom);
            i_bp_bid    = BID_W'($urandom);
            i_bp_taken  = 1'($urandom);
            i_bp_hit    = ($urandom_range(0, 3) != 0);
            i_bp_target = 32'($urandom_range(1, 3) * 16);
            for (int c = 0; c < NCH; c++) begin
                i_bc_valid[c] = ($urandom_range(0, 2) != 0);
                ix = $urandom_range(0, DEPTH - 1);
                rb = BID_W'($urandom);
                if ($urandom_range(0, 3) != 0) rb = mdl[ix].bid;
                if (pend.valid && $urandom_range(0, 2) == 0) rb = pend.bid;
                i_bc_bid[c*BID_W +: BID_W] = rb;
                i_bc_taken[c] = 1'($urandom);
                i_bc_target[c*ADDR_W +: ADDR_W] = ($urandom_range(0, 1) == 0) ?
                    mdl[int'(rb) % DEPTH].target : 32'($urandom_range(1, 3) * 16);
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
